// File: rtl/qspi_pkg.sv
// Shared encodings for the QSPI burst bridge: host commands, FSM state codes
// and status-word field offsets (status word exists only with QSPI_STATUS_EN).
package qspi_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    // IDLE is the all-zero code so a reset state reads as zero; others are one-hot.
    localparam int ST_W = 5;
    localparam logic [ST_W-1:0] ST_IDLE  = 5'b00000;
    localparam logic [ST_W-1:0] ST_ADDR  = 5'b00001;
    localparam logic [ST_W-1:0] ST_READ  = 5'b00010;
    localparam logic [ST_W-1:0] ST_WRITE = 5'b00100;
    localparam logic [ST_W-1:0] ST_DRAIN = 5'b01000;
    localparam logic [ST_W-1:0] ST_STAT  = 5'b10000;

    // Status word: beats_done occupies [bw:0], flags and cmd sit directly above it.
    function automatic int stat_err_ofs(input int bw);
        return bw + 1;
    endfunction

    function automatic int stat_abort_ofs(input int bw);
        return bw + 2;
    endfunction

    function automatic int stat_cmd_ofs(input int bw);
        return bw + 3;
    endfunction

endpackage

// File: rtl/qspi_credit_cnt.sv
// Outstanding-read credit counter: counts reads issued but not yet returned.
module qspi_credit_cnt #(
    parameter int MAX_OUTST = 4,
    parameter int CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_OUTST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + ONE;
        end else if (dec && !inc) begin
            cnt <= cnt - ONE;
        end
    end

    assign full  = (cnt == LIMIT);
    assign empty = (cnt == '0);

endmodule

// File: rtl/qspi_burst_bridge.sv
// QSPI-to-TPU burst bridge: decodes host header/address words, runs pipelined
// read bursts with credit tracking or write bursts. Optional QSPI_STATUS_EN.
module qspi_burst_bridge
    import qspi_pkg::*;
#(
    parameter int DW        = 16,
    parameter int AW        = 22,
    parameter int BW        = 8,
    parameter int MAX_OUTST = 4,
    parameter int STRIDE    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] rdata,
    input  logic          rvalid,
    output logic          ren,
    output logic [DW-1:0] wdata,
    output logic          wen,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] mosi,
    input  logic          mosi_valid,
    output logic [DW-1:0] miso,
    output logic          miso_valid,
    output logic          busy,
    output logic          err
);

    localparam int AWORDS = (AW + DW - 1) / DW;
    localparam int AWC    = (AWORDS > 1) ? $clog2(AWORDS) : 1;
    localparam int CW     = $clog2(MAX_OUTST + 1);

    localparam logic [BW:0]    ONE_B  = (BW + 1)'(1);
    localparam logic [AWC-1:0] ONE_A  = AWC'(1);
    localparam logic [AWC-1:0] LAST_A = AWC'(AWORDS - 1);
    localparam logic [AW-1:0]  STEP   = AW'(STRIDE);

`ifdef QSPI_STATUS_EN
    localparam logic [ST_W-1:0] ST_END = ST_STAT;
`else
    localparam logic [ST_W-1:0] ST_END = ST_IDLE;
`endif

    logic [ST_W-1:0]      state;
    logic [1:0]           cmd_q;
    logic [BW:0]          total;
    logic [BW:0]          issued;
    logic [BW:0]          done_cnt;
    logic [BW:0]          done_inc;
    logic [AWC-1:0]       aw_idx;
    logic [AWORDS*DW-1:0] base_sh;
    logic [AWORDS*DW-1:0] base_cat;
    logic [AW-1:0]        cur;
    logic [CW-1:0]        outst;
    logic                 cr_full;
    logic                 cr_empty;

    logic [1:0]    hdr_cmd;
    logic [BW-1:0] hdr_len;
    logic          st_idle;
    logic          st_read;
    logic          aw_last;
    logic          rv_ok;
    logic          rv_bad;
    logic          rd_last;
    logic          abort;
    logic          ren_c;

    assign hdr_cmd  = mosi[DW-1:DW-2];
    assign hdr_len  = mosi[BW-1:0];
    assign st_idle  = (state == ST_IDLE);
    assign st_read  = (state == ST_READ);
    assign aw_last  = (aw_idx == LAST_A);
    assign done_inc = done_cnt + ONE_B;
    assign rv_ok    = rvalid && !cr_empty;
    assign rv_bad   = rvalid && cr_empty;
    assign rd_last  = st_read && rv_ok && (done_inc == total);
    assign abort    = st_read && mosi_valid && !rd_last;

    // A host word during READ is an abort, so it blocks the request in the same cycle.
    assign ren_c = st_read && !mosi_valid && (issued < total) && !cr_full;
    assign ren   = ren_c;
    assign busy  = !st_idle;

    // Final address word is combined with the stored lower words before registering.
    always_comb begin
        base_cat = base_sh;
        base_cat[(AWORDS-1)*DW +: DW] = mosi;
    end

    qspi_credit_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CW        (CW)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ren_c),
        .dec   (rv_ok),
        .clr   (st_idle),
        .cnt   (outst),
        .full  (cr_full),
        .empty (cr_empty)
    );

`ifdef QSPI_STATUS_EN
    logic aborted;
    logic err_seen;

    function automatic logic [DW-1:0] stat_word(input logic [1:0] c, input logic ab,
                                                input logic es, input logic [BW:0] n);
        logic [DW-1:0] w;
        w = '0;
        w[BW:0] = n;
        w[stat_err_ofs(BW)] = es;
        w[stat_abort_ofs(BW)] = ab;
        w[stat_cmd_ofs(BW) +: 2] = c;
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted  <= 1'b0;
            err_seen <= 1'b0;
        end else if (st_idle) begin
            aborted  <= 1'b0;
            err_seen <= 1'b0;
        end else begin
            if (abort)  aborted  <= 1'b1;
            if (rv_bad) err_seen <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            total      <= '0;
            issued     <= '0;
            done_cnt   <= '0;
            aw_idx     <= '0;
            base_sh    <= '0;
            cur        <= '0;
            addr       <= '0;
            wdata      <= '0;
            wen        <= 1'b0;
            miso       <= '0;
            miso_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            wen        <= 1'b0;
            miso_valid <= 1'b0;
            err        <= rv_bad;
            case (state)
                ST_IDLE: begin
                    if (mosi_valid) begin
                        case (hdr_cmd)
                            CMD_RD, CMD_WR: begin
                                cmd_q    <= hdr_cmd;
                                total    <= {1'b0, hdr_len} + ONE_B;
                                issued   <= '0;
                                done_cnt <= '0;
                                aw_idx   <= '0;
                                state    <= ST_ADDR;
                            end
                            CMD_ILL: err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (mosi_valid) begin
                        base_sh[int'(aw_idx)*DW +: DW] <= mosi;
                        aw_idx <= aw_idx + ONE_A;
                        if (aw_last) begin
                            addr  <= base_cat[AW-1:0];
                            cur   <= base_cat[AW-1:0];
                            state <= (cmd_q == CMD_RD) ? ST_READ : ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (ren_c) begin
                        addr   <= addr + STEP;
                        issued <= issued + ONE_B;
                    end
                    if (rv_ok) begin
                        miso       <= rdata;
                        miso_valid <= 1'b1;
                        done_cnt   <= done_inc;
                    end
                    if (rd_last) begin
                        state <= ST_END;
                    end else if (abort) begin
                        state <= ST_DRAIN;
                    end
                end
                // wen/addr/wdata are presented the cycle after each host beat.
                ST_WRITE: begin
                    if (mosi_valid) begin
                        wdata    <= mosi;
                        wen      <= 1'b1;
                        addr     <= cur;
                        cur      <= cur + STEP;
                        done_cnt <= done_inc;
                        if (done_inc == total) state <= ST_END;
                    end
                end
                ST_DRAIN: begin
                    if (cr_empty) state <= ST_END;
                end
`ifdef QSPI_STATUS_EN
                ST_STAT: begin
                    miso       <= stat_word(cmd_q, aborted, err_seen, done_cnt);
                    miso_valid <= 1'b1;
                    state      <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Collects bits that are intentionally not consumed (dropped address MSBs, count value).
    logic unused_ok;
    assign unused_ok = ^{base_sh[AWORDS*DW-1 -: DW], base_cat, outst};

endmodule

// File: tb/tb_qspi_burst_bridge.sv
// Directed bench for qspi_burst_bridge: table of per-cycle vectors for decode,
// error and write behaviour, plus hand sequences for read bursts, abort and reset.
module tb_qspi_burst_bridge;

    localparam int DW = 16;
    localparam int AW = 22;
    localparam int BW = 8;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0;
    logic          ren;
    logic [DW-1:0] wdata;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] mosi = '0;
    logic          mosi_valid = 1'b0;
    logic [DW-1:0] miso;
    logic          miso_valid;
    logic          busy;
    logic          err;

    qspi_burst_bridge #(
        .DW(DW), .AW(AW), .BW(BW), .MAX_OUTST(MO), .STRIDE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdata(rdata), .rvalid(rvalid), .ren(ren),
        .wdata(wdata), .wen(wen), .addr(addr), .mosi(mosi), .mosi_valid(mosi_valid),
        .miso(miso), .miso_valid(miso_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Per-cycle vectors: inputs for the cycle, outputs expected in that same cycle.
    typedef struct {
        logic          mv;
        logic [DW-1:0] mw;
        logic          rv;
        logic          e_ren;
        logic          e_wen;
        logic          e_busy;
        logic          e_err;
        logic          e_mval;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_miso;
    } vec_t;

    vec_t tbl[19];

    // Read responder and observation logs.
    int            cyc_n = 0;
    int            lat = 1;
    int            hold_until = 0;
    int            n_req = 0;
    int            n_rv = 0;
    int            max_out = 0;
    int            err_cnt = 0;
    int            ren_at_hold = 0;
    int            due_q[$];
    logic [DW-1:0] data_q[$];
    logic [AW-1:0] ren_q[$];
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] miso_q[$];

    task automatic clear_logs();
        due_q.delete();
        data_q.delete();
        ren_q.delete();
        sent_q.delete();
        miso_q.delete();
        n_req = 0;
        n_rv = 0;
        max_out = 0;
        err_cnt = 0;
        ren_at_hold = 0;
    endtask

    task automatic tick(input logic mv, input logic [DW-1:0] mw);
        @(posedge clk);
        #1;
        if (cyc_n == hold_until) ren_at_hold = n_req;
        mosi_valid = mv;
        mosi = mw;
        rvalid = 1'b0;
        rdata = '0;
        if (due_q.size() > 0 && cyc_n >= hold_until && due_q[0] <= cyc_n) begin
            due_q.delete(0);
            rvalid = 1'b1;
            rdata = data_q.pop_front();
            sent_q.push_back(rdata);
            n_rv++;
        end
        #1;
        if (ren) begin
            ren_q.push_back(addr);
            due_q.push_back(cyc_n + lat);
            data_q.push_back(16'h5000 + 16'(n_req));
            n_req++;
        end
        if (n_req - n_rv > max_out) max_out = n_req - n_rv;
        if (miso_valid) miso_q.push_back(miso);
        if (err) err_cnt++;
        cyc_n++;
    endtask

    task automatic do_read(input string nm, input logic [AW-1:0] base, input int len,
                           input int l, input int hold);
        bit            fin;
        int            bad;
        logic [AW-1:0] ea;
        logic [DW-1:0] hdr;
        clear_logs();
        lat = l;
        hold_until = cyc_n + 3 + hold;
        hdr = {2'b01, 6'b0, 8'(len)};
        tick(1'b1, hdr);
        tick(1'b1, base[15:0]);
        tick(1'b1, {10'b0, base[21:16]});
        fin = 1'b0;
        for (int k = 0; k < 3000 && !fin; k++) begin
            tick(1'b0, '0);
            if (!busy) fin = 1'b1;
        end
        chk({nm, " finished"}, 32'(fin), 32'd1);
        tick(1'b0, '0);
        tick(1'b0, '0);
        chk({nm, " ren count"}, 32'(ren_q.size()), 32'(len + 1));
        bad = 0;
        for (int i = 0; i < ren_q.size(); i++) begin
            ea = base + AW'(i);
            if (ren_q[i] !== ea) bad++;
        end
        chk({nm, " ren addr mismatches"}, 32'(bad), 32'd0);
`ifdef QSPI_STATUS_EN
        chk({nm, " miso count"}, 32'(miso_q.size()), 32'(sent_q.size() + 1));
        if (miso_q.size() == sent_q.size() + 1)
            chk({nm, " status"}, 32'(miso_q[sent_q.size()]), (32'd1 << 11) | 32'(len + 1));
`else
        chk({nm, " miso count"}, 32'(miso_q.size()), 32'(sent_q.size()));
`endif
        bad = 0;
        for (int i = 0; i < sent_q.size() && i < miso_q.size(); i++)
            if (miso_q[i] !== sent_q[i]) bad++;
        chk({nm, " miso data mismatches"}, 32'(bad), 32'd0);
        chk({nm, " outstanding within limit"}, 32'(max_out <= MO), 32'd1);
        chk({nm, " err pulses"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // cmd=11 header, stray rvalid in IDLE, NOP header, then WRITE len=2 @0x100
        tbl[0]  = '{1'b1, 16'hC000, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 1, 0, 22'h0, 16'h0, 16'h0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 1, 0, 22'h0, 16'h0, 16'h0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[5]  = '{1'b1, 16'h0000, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[7]  = '{1'b1, 16'h8002, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[8]  = '{1'b1, 16'h0100, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[10] = '{1'b1, 16'h0000, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[12] = '{1'b1, 16'hAAAA, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 0, 1, 1, 0, 0, 22'h100, 16'hAAAA, 16'h0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[15] = '{1'b1, 16'hBBBB, 1'b0, 0, 0, 1, 0, 0, 22'h0, 16'h0, 16'h0};
        tbl[16] = '{1'b1, 16'hCCCC, 1'b0, 0, 1, 1, 0, 0, 22'h101, 16'hBBBB, 16'h0};
`ifdef QSPI_STATUS_EN
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 0, 1, 1, 0, 0, 22'h102, 16'hCCCC, 16'h0};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 1, 22'h0, 16'h0, 16'h1003};
`else
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 0, 1, 0, 0, 0, 22'h102, 16'hCCCC, 16'h0};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 0, 0, 0, 0, 0, 22'h0, 16'h0, 16'h0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("reset flags", {27'b0, ren, wen, busy, err, miso_valid}, 32'd0);
        chk("reset addr", 32'(addr), 32'd0);
        chk("reset miso", 32'(miso), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            mosi_valid = tbl[i].mv;
            mosi = tbl[i].mw;
            rvalid = tbl[i].rv;
            rdata = 16'hDEAD;
            #1;
            chk($sformatf("vec%0d flags ren/wen/busy/err/mval", i),
                {27'b0, ren, wen, busy, err, miso_valid},
                {27'b0, tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_busy, tbl[i].e_err, tbl[i].e_mval});
            if (tbl[i].e_wen) begin
                chk($sformatf("vec%0d addr", i), 32'(addr), 32'(tbl[i].e_addr));
                chk($sformatf("vec%0d wdata", i), 32'(wdata), 32'(tbl[i].e_wdata));
            end
            if (tbl[i].e_mval)
                chk($sformatf("vec%0d miso", i), 32'(miso), 32'(tbl[i].e_miso));
        end

        // READ len=3 @0x12345, rvalid two cycles after each ren
        do_read("t1", 22'h12345, 3, 2, 0);

        // READ len=7 with returns withheld 10 cycles: credit limit stalls at 4
        do_read("t2", 22'h000200, 7, 1, 10);
        chk("t2 ren before release", 32'(ren_at_hold), 32'd4);

        // Abort after 2 of 6 beats issued
        clear_logs();
        lat = 1;
        hold_until = cyc_n + 1000;
        tick(1'b1, 16'h4005);
        tick(1'b1, 16'h0040);
        tick(1'b1, 16'h0000);
        tick(1'b0, '0);
        tick(1'b0, '0);
        chk("t4 ren before abort", 32'(n_req), 32'd2);
        tick(1'b1, 16'hFFFF);
        chk("t4 ren in abort cycle", 32'(n_req), 32'd2);
        tick(1'b1, 16'h4001);
        tick(1'b0, '0);
        chk("t4 busy while draining", 32'(busy), 32'd1);
        hold_until = cyc_n;
        begin
            bit fin;
            fin = 1'b0;
            for (int k = 0; k < 20 && !fin; k++) begin
                tick(1'b0, '0);
                if (!busy) fin = 1'b1;
            end
            chk("t4 drain finished", 32'(fin), 32'd1);
        end
        tick(1'b0, '0);
        tick(1'b0, '0);
        chk("t4 ren total", 32'(n_req), 32'd2);
        chk("t4 rvalid returned", 32'(n_rv), 32'd2);
`ifdef QSPI_STATUS_EN
        chk("t4 miso count", 32'(miso_q.size()), 32'd1);
        if (miso_q.size() == 1) chk("t4 status", 32'(miso_q[0]), 32'h0C00);
`else
        chk("t4 miso count", 32'(miso_q.size()), 32'd0);
`endif
        chk("t4 err pulses", 32'(err_cnt), 32'd0);

        // Asynchronous reset in the middle of a WRITE
        clear_logs();
        tick(1'b1, 16'h8003);
        tick(1'b1, 16'h0200);
        tick(1'b1, 16'h0000);
        tick(1'b1, 16'h1234);
        tick(1'b0, '0);
        chk("t6 wen before reset", 32'(wen), 32'd1);
        chk("t6 addr before reset", 32'(addr), 32'h200);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 flags in reset", {27'b0, ren, wen, busy, err, miso_valid}, 32'd0);
        chk("t6 addr in reset", 32'(addr), 32'd0);
        chk("t6 wdata in reset", 32'(wdata), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // After reset: READ of 256 beats wrapping past the top of the address space
        do_read("t6 wrap", 22'h3FFFF0, 255, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
